tc_accum_bank: RTL and testbench

TC_ACCUM_BANK -- requirements
Module: tc_accum_bank

---
 rtl/tc_accum_bank.sv | 148 ++++++++++++++
 tb/tb_tc_accum_bank.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_accum_bank.sv
// Purpose: bank of timer/counter accumulators with a coherent shadow snapshot, single reads and full scans.
// Latency: one cycle from a sampled read request (or each scan step) to the registered word on tcAccumOut.
// Backpressure: none; reads and scan starts arriving mid-scan are dropped, and a scan always streams every channel back to back.
module tc_accum_bank #(
   parameter int TC_NUMBERS  = 8,
   parameter int TC_ACC_LEN  = 8,
   parameter int TC_ADDR_LEN = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [TC_ACC_LEN*TC_NUMBERS-1:0] tcAccumIn,
   input  logic                             tcAccumRead,
   input  logic [TC_ADDR_LEN-1:0]           tcAddr,
   input  logic                             tcSnap,
   input  logic                             tcUseShadow,
   input  logic                             tcScanStart,
   output logic [TC_ACC_LEN-1:0]            tcAccumOut,
   output logic                             tcAccumValid,
   output logic [TC_ADDR_LEN-1:0]           tcOutIdx,
   output logic                             tcAddrErr,
   output logic                             tcBusy,
   output logic                             tcScanDone
);

   // Every address has a slot so out-of-range lookups are well defined (they read zero).
   localparam int                     LP_SLOTS = 1 << TC_ADDR_LEN;
   localparam logic [TC_ADDR_LEN:0]   LP_NUM   = (TC_ADDR_LEN+1)'(TC_NUMBERS);
   localparam logic [TC_ADDR_LEN-1:0] LP_LAST  = TC_ADDR_LEN'(TC_NUMBERS-1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t                           r_state;
   state_t                           w_state_nxt;
   logic                             r_scan_pend;
   logic                             w_scan_pend_nxt;
   logic [TC_ADDR_LEN-1:0]           r_idx;
   logic [TC_ADDR_LEN-1:0]           w_idx_nxt;
   logic [TC_ACC_LEN*TC_NUMBERS-1:0] r_shadow;
   logic [TC_ACC_LEN-1:0]            r_out;
   logic [TC_ACC_LEN-1:0]            w_out_nxt;
   logic [TC_ADDR_LEN-1:0]           r_out_idx;
   logic [TC_ADDR_LEN-1:0]           w_out_idx_nxt;
   logic                             r_vld;
   logic                             w_vld_nxt;
   logic                             r_err;
   logic                             w_err_nxt;
   logic                             r_done;
   logic                             w_done_nxt;
   logic [TC_ACC_LEN-1:0]            w_src [LP_SLOTS];

   // Per-word source select: shadow bank or live inputs, unused slots read as zero.
   always_comb begin
      for (int k = 0; k < LP_SLOTS; k++) begin
         w_src[k] = '0;
      end
      for (int k = 0; k < TC_NUMBERS; k++) begin
         w_src[k] = tcUseShadow ? r_shadow[k*TC_ACC_LEN +: TC_ACC_LEN]
                                : tcAccumIn[k*TC_ACC_LEN +: TC_ACC_LEN];
      end
   end

   // Next state and next output word; pulses default low, data/index hold.
   always_comb begin
      w_state_nxt     = r_state;
      w_scan_pend_nxt = r_scan_pend;
      w_idx_nxt       = r_idx;
      w_out_nxt       = r_out;
      w_out_idx_nxt   = r_out_idx;
      w_vld_nxt       = 1'b0;
      w_err_nxt       = 1'b0;
      w_done_nxt      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (tcAccumRead) begin
               w_vld_nxt     = 1'b1;
               w_out_idx_nxt = tcAddr;
               if ({1'b0, tcAddr} >= LP_NUM) begin
                  w_err_nxt = 1'b1;
                  w_out_nxt = '0;
               end else begin
                  w_out_nxt = w_src[tcAddr];
               end
            end
            // A scan request colliding with a read is held one cycle so the read goes first.
            if (r_scan_pend || (tcScanStart && !tcAccumRead)) begin
               w_state_nxt     = ST_SCAN;
               w_idx_nxt       = '0;
               w_scan_pend_nxt = 1'b0;
            end else if (tcScanStart) begin
               w_scan_pend_nxt = 1'b1;
            end
         end
         ST_SCAN: begin
            w_vld_nxt     = 1'b1;
            w_out_nxt     = w_src[r_idx];
            w_out_idx_nxt = r_idx;
            w_idx_nxt     = r_idx + 1'b1;
            if (r_idx == LP_LAST) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   // State, scan index and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_scan_pend <= 1'b0;
         r_idx       <= '0;
         r_out       <= '0;
         r_out_idx   <= '0;
         r_vld       <= 1'b0;
         r_err       <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_scan_pend <= w_scan_pend_nxt;
         r_idx       <= w_idx_nxt;
         r_out       <= w_out_nxt;
         r_out_idx   <= w_out_idx_nxt;
         r_vld       <= w_vld_nxt;
         r_err       <= w_err_nxt;
         r_done      <= w_done_nxt;
      end
   end

   // Shadow bank captures all channels on one edge; a read on that same edge still sees the old copy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_shadow <= '0;
      end else if (tcSnap) begin
         r_shadow <= tcAccumIn;
      end
   end

   assign tcAccumOut   = r_out;
   assign tcAccumValid = r_vld;
   assign tcOutIdx     = r_out_idx;
   assign tcAddrErr    = r_err;
   assign tcBusy       = (r_state == ST_SCAN);
   assign tcScanDone   = r_done;

endmodule

// File: tb/tb_tc_accum_bank.sv
// Bench for tc_accum_bank: vector table for single reads, directed multi-cycle sequences,
// and randomized reads/snaps/scans scored against an array model of live and shadow banks.
module tb_tc_accum_bank;
   localparam int N = 8;
   localparam int W = 8;
   localparam int A = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [W*N-1:0] acc_in;
   logic           rd;
   logic [A-1:0]   addr;
   logic           snap;
   logic           use_sh;
   logic           scan_start;
   logic [W-1:0]   out;
   logic           vld;
   logic [A-1:0]   oidx;
   logic           err;
   logic           busy;
   logic           done;

   int n_vec = 0;
   int n_bad = 0;

   logic [W-1:0] m_live [N];
   logic [W-1:0] m_shad [N];

   typedef struct {
      logic [A-1:0] addr;
      logic         sh;
      logic [W-1:0] exp_out;
      logic         exp_err;
   } vec_t;

   vec_t tbl [9];

   always #5 clk = ~clk;

   tc_accum_bank #(.TC_NUMBERS(N), .TC_ACC_LEN(W), .TC_ADDR_LEN(A)) dut (
      .clk          (clk),
      .reset        (reset),
      .tcAccumIn    (acc_in),
      .tcAccumRead  (rd),
      .tcAddr       (addr),
      .tcSnap       (snap),
      .tcUseShadow  (use_sh),
      .tcScanStart  (scan_start),
      .tcAccumOut   (out),
      .tcAccumValid (vld),
      .tcOutIdx     (oidx),
      .tcAddrErr    (err),
      .tcBusy       (busy),
      .tcScanDone   (done)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int k, input logic [W-1:0] v);
      acc_in[k*W +: W] = v;
      m_live[k] = v;
   endtask

   // Snap on the next edge; the model shadow takes the live values present before that edge.
   task automatic do_snap;
      snap = 1'b1;
      for (int k = 0; k < N; k++) m_shad[k] = m_live[k];
      tick;
      snap = 1'b0;
   endtask

   task automatic read_chk(input string nm, input logic [A-1:0] a, input logic sh,
                           input logic [W-1:0] eo, input logic ee);
      rd = 1'b1; addr = a; use_sh = sh;
      tick;
      rd = 1'b0;
      chk({nm, " vld"}, vld, 1);
      chk({nm, " out"}, out, eo);
      chk({nm, " idx"}, oidx, a);
      chk({nm, " err"}, err, ee);
      chk({nm, " busy"}, busy, 0);
      tick;
      chk({nm, " vld drop"}, vld, 0);
      chk({nm, " out hold"}, out, eo);
      chk({nm, " idx hold"}, oidx, a);
      chk({nm, " err drop"}, err, 0);
   endtask

   // Checks nwords scan words; the start edge has already been taken.
   task automatic scan_words(input string nm, input bit rnd, input int nwords, input int rd_at);
      logic [W-1:0] e;
      for (int i = 0; i < nwords; i++) begin
         if (rnd) begin
            use_sh = 1'($urandom);
            if ($urandom_range(2) == 0) set_ch($urandom_range(N-1), 8'($urandom));
         end
         if (i == rd_at) begin
            rd = 1'b1; scan_start = 1'b1; addr = 4'd1;
         end
         e = use_sh ? m_shad[i] : m_live[i];
         if (rnd && $urandom_range(3) == 0) begin
            snap = 1'b1;
            for (int k = 0; k < N; k++) m_shad[k] = m_live[k];
         end
         tick;
         snap = 1'b0; rd = 1'b0; scan_start = 1'b0;
         chk($sformatf("%s w%0d vld", nm, i), vld, 1);
         chk($sformatf("%s w%0d out", nm, i), out, e);
         chk($sformatf("%s w%0d idx", nm, i), oidx, i);
         chk($sformatf("%s w%0d done", nm, i), done, (i == N-1) ? 1 : 0);
         chk($sformatf("%s w%0d err", nm, i), err, 0);
         chk($sformatf("%s w%0d busy", nm, i), busy, (i < N-1) ? 1 : 0);
      end
   endtask

   task automatic start_scan(input string nm);
      scan_start = 1'b1;
      tick;
      scan_start = 1'b0;
      chk({nm, " busy up"}, busy, 1);
      chk({nm, " no word yet"}, vld, 0);
   endtask

   task automatic scan_tail(input string nm);
      for (int j = 0; j < 2; j++) begin
         tick;
         chk($sformatf("%s tail%0d vld", nm, j), vld, 0);
         chk($sformatf("%s tail%0d busy", nm, j), busy, 0);
      end
   endtask

   initial begin
      logic [W-1:0] eo;
      logic         ee;
      logic         exp_vld;
      logic [A-1:0] exp_idx;
      int           busy_cnt;

      reset = 1'b0; acc_in = '0; rd = 0; addr = '0; snap = 0; use_sh = 0; scan_start = 0;
      for (int k = 0; k < N; k++) begin m_live[k] = '0; m_shad[k] = '0; end

      tbl[0] = '{4'd5,  1'b0, 8'hA5, 1'b0};
      tbl[1] = '{4'd0,  1'b0, 8'hA0, 1'b0};
      tbl[2] = '{4'd7,  1'b0, 8'hA7, 1'b0};
      tbl[3] = '{4'd8,  1'b0, 8'h00, 1'b1};
      tbl[4] = '{4'd9,  1'b0, 8'h00, 1'b1};
      tbl[5] = '{4'd15, 1'b0, 8'h00, 1'b1};
      tbl[6] = '{4'd2,  1'b1, 8'h22, 1'b0};
      tbl[7] = '{4'd7,  1'b1, 8'h77, 1'b0};
      tbl[8] = '{4'd9,  1'b1, 8'h00, 1'b1};

      // Reset state
      tick; tick;
      chk("rst out", out, 0);
      chk("rst vld", vld, 0);
      chk("rst idx", oidx, 0);
      chk("rst err", err, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      reset = 1'b1;
      tick;

      // Vector table: shadow holds k*0x11, live holds 0xA0+k
      for (int k = 0; k < N; k++) set_ch(k, 8'(k * 8'h11));
      do_snap;
      for (int k = 0; k < N; k++) set_ch(k, 8'hA0 + 8'(k));
      for (int v = 0; v < 9; v++)
         read_chk($sformatf("vec%0d", v), tbl[v].addr, tbl[v].sh, tbl[v].exp_out, tbl[v].exp_err);

      // Snapshot coherence and snap-vs-read ordering
      set_ch(2, 8'h10);
      do_snap;
      set_ch(2, 8'h20);
      read_chk("snap shadow", 4'd2, 1'b1, 8'h10, 1'b0);
      read_chk("snap live", 4'd2, 1'b0, 8'h20, 1'b0);
      set_ch(2, 8'h30);
      snap = 1'b1;
      read_chk("snap same edge", 4'd2, 1'b1, 8'h10, 1'b0);
      for (int k = 0; k < N; k++) m_shad[k] = m_live[k];
      read_chk("snap after", 4'd2, 1'b1, 8'h30, 1'b0);

      // Full scan over k*3 with a busy-length count
      use_sh = 1'b0;
      for (int k = 0; k < N; k++) set_ch(k, 8'(k * 3));
      scan_start = 1'b1;
      busy_cnt = 0;
      for (int c = 0; c < N + 4; c++) begin
         tick;
         scan_start = 1'b0;
         if (busy) busy_cnt++;
         if (c >= 1 && c <= N) begin
            chk($sformatf("scan3 w%0d vld", c-1), vld, 1);
            chk($sformatf("scan3 w%0d out", c-1), out, (c-1) * 3);
            chk($sformatf("scan3 w%0d idx", c-1), oidx, c-1);
            chk($sformatf("scan3 w%0d done", c-1), done, (c == N) ? 1 : 0);
         end else begin
            chk($sformatf("scan3 c%0d idle vld", c), vld, 0);
         end
      end
      chk("scan3 busy cycles", busy_cnt, N);

      // Read and scan-start pulsed mid-scan are dropped
      start_scan("scanrd");
      scan_words("scanrd", 1'b0, N, 3);
      scan_tail("scanrd");

      // Read and scan start on the same edge: read first, scan next edge
      rd = 1'b1; addr = 4'd6; scan_start = 1'b1;
      tick;
      rd = 1'b0; scan_start = 1'b0;
      chk("collide read vld", vld, 1);
      chk("collide read out", out, 8'd18);
      chk("collide busy low", busy, 0);
      tick;
      chk("collide busy up", busy, 1);
      chk("collide gap vld", vld, 0);
      scan_words("collide", 1'b0, N, -1);
      scan_tail("collide");

      // Reset after the third scan word
      start_scan("rstscan");
      scan_words("rstscan", 1'b0, 3, -1);
      reset = 1'b0;
      tick;
      reset = 1'b1;
      for (int k = 0; k < N; k++) m_shad[k] = '0;
      chk("rstscan out", out, 0);
      chk("rstscan vld", vld, 0);
      chk("rstscan idx", oidx, 0);
      chk("rstscan busy", busy, 0);
      chk("rstscan done", done, 0);
      chk("rstscan err", err, 0);
      scan_tail("rstscan");
      read_chk("rstscan live", 4'd4, 1'b0, 8'd12, 1'b0);
      read_chk("rstscan shadow", 4'd2, 1'b1, 8'd0, 1'b0);

      // Randomized reads and snaps against the model
      eo = out; exp_idx = oidx;
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(1) == 0) set_ch($urandom_range(N-1), 8'($urandom));
         use_sh = 1'($urandom);
         rd = ($urandom_range(2) != 0);
         addr = 4'($urandom);
         exp_vld = rd;
         ee = 1'b0;
         if (rd) begin
            exp_idx = addr;
            if (int'(addr) >= N) begin eo = '0; ee = 1'b1; end
            else eo = use_sh ? m_shad[addr] : m_live[addr];
         end
         snap = ($urandom_range(3) == 0);
         if (snap) for (int k = 0; k < N; k++) m_shad[k] = m_live[k];
         tick;
         snap = 1'b0; rd = 1'b0;
         chk("rnd vld", vld, exp_vld);
         chk("rnd out", out, eo);
         chk("rnd idx", oidx, exp_idx);
         chk("rnd err", err, ee);
      end

      // Randomized scans with per-word source selection, live changes and snaps
      for (int s = 0; s < 6; s++) begin
         start_scan($sformatf("rscan%0d", s));
         scan_words($sformatf("rscan%0d", s), 1'b1, N, -1);
         scan_tail($sformatf("rscan%0d", s));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
